video_pattern_source: RTL and testbench
=======================================

# video_pattern_source

Synthetic video stream transmitter. It produces the pixel bus that the conv_kernel receive path consumes: active-low sync/blank, 13-bit row/col, 8-bit RGB and the color bit. A moving square "ball" bounces inside a 640x480 active area, so the denoise, box and ball-tracking chain can be driven from a known trajectory, both on hardware and in simulation.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (lines)
- PIXEL_DEPTH, 8, bits per color channel
- BALL_SIZE, 16, ball edge length (pixels)
- BALL_LEVEL / BG_LEVEL, 8'hFF / 8'h20, channel value inside ball / active background

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- en_i  in  1  pixel tick; timing counters advance only on clk edges with en_i=1
- run  in  1  motion enable, sampled at the frame wrap
- step_x, step_y  in  4  per-frame displacement magnitude, sampled at the frame wrap
- vs_no, hs_no, blank_no  out  1  active-low sync and blank
- color_o  out  1  1 inside the ball and inside the active region
- row_o, col_o  out  13  current line / pixel counters
- R_o, G_o, B_o  out  PIXEL_DEPTH  pixel value
- frame_start_o  out  1  single-clk pulse after each frame wrap

## Operation
- Derived values:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = 525.
  - XMAX = H_ACTIVE-BALL_SIZE = 624.
  - YMAX = V_ACTIVE-BALL_SIZE = 464.
- Counter advance, on each en_i=1 edge:
  - col increments.
  - At col=H_TOTAL-1, col wraps to 0 and row increments.
  - At row=V_TOTAL-1 and col=H_TOTAL-1, both wrap to 0. This edge is the "frame wrap".
- Output decode, from registered state only:
  - hs_no=0 for col in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
  - vs_no=0 for row in [490,491].
  - blank_no=1 iff col<H_ACTIVE and row<V_ACTIVE.
  - Ball hit: bx<=col<bx+BALL_SIZE and by<=row<by+BALL_SIZE, with blank_no=1.
  - color_o = ball hit.
  - RGB = BALL_LEVEL when color_o=1; BG_LEVEL when blank_no=1 and color_o=0; 0 when blank_no=0.
- Motion FSM, states STOP and MOVE:
  - At each frame wrap the next state is MOVE if run=1, else STOP.
  - The transition is evaluated at the frame wrap only. run changes mid-frame have no effect until the next frame wrap.
- Position update:
  - Applies only at a frame wrap with run=1. That same edge also loads the new bx/by, so the new frame is drawn at the new position.
  - Per axis, with position p, step s, limit M and direction d (1 = +):
    - d=1: if p+s>=M, then p=M and d flips; else p=p+s.
    - d=0: if s>=p, then p=0 and d flips; else p=p-s.
    - s=0: p and d are unchanged, including at a boundary.
  - Arithmetic is unsigned 13-bit. p+s cannot overflow.
- Reset values:
  - Counters: row=col=0.
  - Ball: bx=312, by=232, both directions +, state STOP.
  - Outputs during and after reset:
    - hs_no=1, vs_no=1, blank_no=1
    - color_o=0
    - RGB=BG_LEVEL
    - row_o=col_o=0
    - frame_start_o=0

## Timing
- row_o, col_o, the syncs, blank_no, color_o and RGB all describe the same pixel in the same cycle. There is no skew between them.
- A single en_i edge changes counter state. The decoded outputs reflect it in that edge's following cycle.
- en_i=0 holds all state. Outputs are static while en_i=0.
- frame_start_o is registered. It is 1 for exactly one clk following the frame-wrap edge, independent of later en_i.
- With en_i held at 1:
  - line = 800 clk
  - frame = 420000 clk
  - hs low 96 clk
  - vs low 1600 clk
- rstn=0 takes priority over en_i at any point mid-frame, including a coinciding frame wrap. At the next edge all state holds reset values.

## Structure
- Package video_timing_pkg contains:
  - the 640x480 timing constants
  - H_TOTAL/V_TOTAL
  - the motion_state_t enum {STOP, MOVE}
- Sub-module ball_axis holds one axis: position register, direction flag and bounce/clamp logic. It has inputs limit, step, update and rstn, and a reset-position parameter. It is instantiated twice: (XMAX, step_x, 312) and (YMAX, step_y, 232).
- Top level: counters, sync/blank decode, ball hit, RGB mux, motion FSM, frame_start register.

## Test plan
- Reset, en_i=1: first hs_no low at col 656 (656 clk after release), 96 clk wide, period 800; blank_no low at col 640..799.
- Full frame, en_i=1: vs_no low rows 490–491 (1600 clk); frame_start_o one-clk pulse every 420000 clk; row/col return to 0,0.
- en_i=1 every other clk: line period 1600 clk; outputs constant on en_i=0 cycles.
- run=1, step_x=15, step_y=0 from reset:
  - bx after N wraps = 312+15N through N=20 (612).
  - Wrap 21: bx=624 and direction flips.
  - Wrap 22: bx=609.
  - by stays 232 throughout.
- Pixel check at reset position:
  - (row 232, col 312): color_o=1, RGB=FF.
  - (232, 328): color_o=0, RGB=20.
  - (232, 700): RGB=00.
  - run=0 across a wrap: bx/by unchanged.
- rstn=0 for one edge at row 100, col 400, and again coincident with a frame wrap: next cycle row=col=0, bx=312, by=232, STOP, frame_start_o=0.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared 640x480 timing constants, pixel levels and motion state type for the
// synthetic video pattern source.
package video_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CW          = 13;
  localparam int PIXEL_DEPTH = 8;
  localparam int BALL_SIZE   = 16;
  localparam int X_RESET     = 312;
  localparam int Y_RESET     = 232;

  localparam logic [PIXEL_DEPTH-1:0] BALL_LEVEL = 8'hFF;
  localparam logic [PIXEL_DEPTH-1:0] BG_LEVEL   = 8'h20;

  typedef enum logic {
    STOP = 1'b0,
    MOVE = 1'b1
  } motion_state_t;

endpackage

// File: rtl/ball_axis.sv
// One axis of the bouncing ball: position, direction and clamp-and-flip at
// either edge of [0, limit].
module ball_axis
  import video_timing_pkg::*;
#(
  parameter int RESET_POS = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          update,
  input  logic [CW-1:0] limit,
  input  logic [3:0]    step,
  output logic [CW-1:0] pos
);

  logic          dir_q;
  logic [CW-1:0] pos_q;
  logic [CW-1:0] step_w;

  assign step_w = {{(CW-4){1'b0}}, step};
  assign pos    = pos_q;

  // A zero step leaves both position and direction alone, even at an edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pos_q <= CW'(RESET_POS);
      dir_q <= 1'b1;
    end else if (update && (step_w != '0)) begin
      if (dir_q) begin
        if (pos_q + step_w >= limit) begin
          pos_q <= limit;
          dir_q <= 1'b0;
        end else begin
          pos_q <= pos_q + step_w;
        end
      end else begin
        if (step_w >= pos_q) begin
          pos_q <= '0;
          dir_q <= 1'b1;
        end else begin
          pos_q <= pos_q - step_w;
        end
      end
    end
  end

endmodule

// File: rtl/video_pattern_source.sv
// Synthetic video transmitter: raster counters, sync/blank decode and a square
// ball bouncing inside the active area, advanced once per frame.
module video_pattern_source
  import video_timing_pkg::*;
#(
  parameter int H_ACT   = H_ACTIVE,
  parameter int H_FRONT = H_FP,
  parameter int H_SYN   = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_SYN   = V_SYNC,
  parameter int V_BACK  = V_BP,
  parameter int BALL    = BALL_SIZE,
  parameter int X_INIT  = X_RESET,
  parameter int Y_INIT  = Y_RESET
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en_i,
  input  logic                   run,
  input  logic [3:0]             step_x,
  input  logic [3:0]             step_y,
  output logic                   vs_no,
  output logic                   hs_no,
  output logic                   blank_no,
  output logic                   color_o,
  output logic [CW-1:0]          row_o,
  output logic [CW-1:0]          col_o,
  output logic [PIXEL_DEPTH-1:0] R_o,
  output logic [PIXEL_DEPTH-1:0] G_o,
  output logic [PIXEL_DEPTH-1:0] B_o,
  output logic                   frame_start_o,
  output motion_state_t          dbg_state
);

  localparam int HT = H_ACT + H_FRONT + H_SYN + H_BACK;
  localparam int VT = V_ACT + V_FRONT + V_SYN + V_BACK;

  localparam logic [CW-1:0] H_LAST   = CW'(HT - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(VT - 1);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACT + H_FRONT);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACT + H_FRONT + H_SYN - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACT + V_FRONT);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACT + V_FRONT + V_SYN - 1);
  localparam logic [CW-1:0] XMAX     = CW'(H_ACT - BALL);
  localparam logic [CW-1:0] YMAX     = CW'(V_ACT - BALL);
  localparam logic [CW-1:0] BSZ      = CW'(BALL);

  logic [CW-1:0]          col_q;
  logic [CW-1:0]          row_q;
  logic                   frame_start_q;
  motion_state_t          state_q;
  logic                   line_end;
  logic                   frame_wrap;
  logic                   pos_update;
  logic [CW-1:0]          bx;
  logic [CW-1:0]          by;
  logic                   active;
  logic                   hit;
  logic [PIXEL_DEPTH-1:0] pix;

  assign line_end   = (col_q == H_LAST);
  assign frame_wrap = en_i && line_end && (row_q == V_LAST);
  assign pos_update = frame_wrap && run;

  // run/step are only looked at on the wrap edge, so the whole next frame is
  // drawn at one position and one motion state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      col_q         <= '0;
      row_q         <= '0;
      frame_start_q <= 1'b0;
      state_q       <= STOP;
    end else begin
      frame_start_q <= frame_wrap;
      if (en_i) begin
        if (line_end) begin
          col_q <= '0;
          row_q <= (row_q == V_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (frame_wrap) begin
        state_q <= run ? MOVE : STOP;
      end
    end
  end

  ball_axis #(.RESET_POS(X_INIT)) u_axis_x (
    .clk    (clk),
    .rstn   (rstn),
    .update (pos_update),
    .limit  (XMAX),
    .step   (step_x),
    .pos    (bx)
  );

  ball_axis #(.RESET_POS(Y_INIT)) u_axis_y (
    .clk    (clk),
    .rstn   (rstn),
    .update (pos_update),
    .limit  (YMAX),
    .step   (step_y),
    .pos    (by)
  );

  // Everything below decodes the same registered counters, so all outputs
  // describe the same pixel in the same cycle.
  assign active = (col_q < CW'(H_ACT)) && (row_q < CW'(V_ACT));
  assign hit    = active && (col_q >= bx) && (col_q < bx + BSZ) &&
                  (row_q >= by) && (row_q < by + BSZ);

  always_comb begin
    pix = '0;
    if (hit) begin
      pix = BALL_LEVEL;
    end else if (active) begin
      pix = BG_LEVEL;
    end
  end

  assign hs_no         = !((col_q >= HS_FIRST) && (col_q <= HS_LAST));
  assign vs_no         = !((row_q >= VS_FIRST) && (row_q <= VS_LAST));
  assign blank_no      = active;
  assign color_o       = hit;
  assign row_o         = row_q;
  assign col_o         = col_q;
  assign R_o           = pix;
  assign G_o           = pix;
  assign B_o           = pix;
  assign frame_start_o = frame_start_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_video_pattern_source.sv
// Directed bench: instance a uses the real 640x480 timing for line-level checks,
// instance b a shrunken raster (80x30, ball 8, start 28/8) for frame and motion.
module tb_video_pattern_source;
  import video_timing_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en_i;
  logic       run;
  logic [3:0] step_x;
  logic [3:0] step_y;

  logic          a_vs, a_hs, a_blank, a_color, a_fs;
  logic [12:0]   a_row, a_col;
  logic [7:0]    a_r, a_g, a_b;
  motion_state_t a_state;

  logic          b_vs, b_hs, b_blank, b_color, b_fs;
  logic [12:0]   b_row, b_col;
  logic [7:0]    b_r, b_g, b_b;
  motion_state_t b_state;

  int checks = 0;
  int errors = 0;

  logic [23:0] line_rgb [80];

  always #5 clk = ~clk;

  video_pattern_source dut_a (
    .clk(clk), .rstn(rstn), .en_i(en_i), .run(run), .step_x(step_x), .step_y(step_y),
    .vs_no(a_vs), .hs_no(a_hs), .blank_no(a_blank), .color_o(a_color),
    .row_o(a_row), .col_o(a_col), .R_o(a_r), .G_o(a_g), .B_o(a_b),
    .frame_start_o(a_fs), .dbg_state(a_state)
  );

  video_pattern_source #(
    .H_ACT(64), .H_FRONT(4), .H_SYN(8), .H_BACK(4),
    .V_ACT(24), .V_FRONT(2), .V_SYN(2), .V_BACK(2),
    .BALL(8), .X_INIT(28), .Y_INIT(8)
  ) dut_b (
    .clk(clk), .rstn(rstn), .en_i(en_i), .run(run), .step_x(step_x), .step_y(step_y),
    .vs_no(b_vs), .hs_no(b_hs), .blank_no(b_blank), .color_o(b_color),
    .row_o(b_row), .col_o(b_col), .R_o(b_r), .G_o(b_g), .B_o(b_b),
    .frame_start_o(b_fs), .dbg_state(b_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_b(input int r, input int c, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 6000 && !found; i++) begin
      if (b_row == 13'(r) && b_col == 13'(c)) found = 1'b1;
      else @(negedge clk);
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_fs(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 6000 && !found; i++) begin
      @(negedge clk);
      if (b_fs) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // Captures one full line of instance b; returns first ball column and ball width.
  task automatic scan_b(input int r, output int first, output int cnt);
    wait_b(r, 0, "scan_sync");
    first = -1;
    cnt = 0;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clk);
      line_rgb[c] = {b_r, b_g, b_b};
      if (b_color) begin
        if (first < 0) first = c;
        cnt++;
      end
    end
  endtask

  int exp_bx [8] = '{33, 38, 43, 48, 53, 56, 51, 46};

  initial begin
    int k, w, p, lo_cnt, lo_first, start_row, bad, vl, vrow, first, cnt;
    logic found;
    logic [12:0] prev_col, prev_row;
    logic prev_hs, prev_blank;
    logic [23:0] prev_rgb, rgb100, rgb700;

    rstn = 1'b0; en_i = 1'b0; run = 1'b0; step_x = 4'd0; step_y = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_hs", 32'(a_hs), 32'd1);
    check("rst_vs", 32'(a_vs), 32'd1);
    check("rst_blank", 32'(a_blank), 32'd1);
    check("rst_color", 32'(a_color), 32'd0);
    check("rst_rgb", 32'({a_r, a_g, a_b}), 32'h202020);
    check("rst_row", 32'(a_row), 32'd0);
    check("rst_col", 32'(a_col), 32'd0);
    check("rst_fs", 32'(a_fs), 32'd0);
    check("rst_state", 32'(a_state), 32'(STOP));

    // Line timing on the real raster.
    rstn = 1'b1; en_i = 1'b1;
    k = 0; found = 1'b0;
    for (int i = 1; i <= 2000 && !found; i++) begin
      @(negedge clk);
      if (!a_hs) begin found = 1'b1; k = i; end
    end
    check("hs_first_clk", 32'(k), 32'd656);
    check("hs_first_col", 32'(a_col), 32'd656);
    w = 0;
    while (!a_hs && w < 2000) begin w++; @(negedge clk); end
    check("hs_width", 32'(w), 32'd96);
    p = 0; found = 1'b0;
    for (int i = 1; i <= 2000 && !found; i++) begin
      @(negedge clk);
      if (!a_hs) begin found = 1'b1; p = w + i; end
    end
    check("hs_period", 32'(p), 32'd800);
    check("hs_row1", 32'(a_row), 32'd1);

    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (a_col == 13'd0) found = 1'b1; else @(negedge clk);
    end
    check("line_sync", 32'(found), 32'd1);
    lo_cnt = 0; lo_first = -1; bad = 0; rgb100 = '0; rgb700 = '1;
    for (int c = 0; c < 800; c++) begin
      if (c > 0) @(negedge clk);
      if (!a_blank) begin
        lo_cnt++;
        if (lo_first < 0) lo_first = c;
      end
      if (!a_vs) bad++;
      if (c == 100) rgb100 = {a_r, a_g, a_b};
      if (c == 700) rgb700 = {a_r, a_g, a_b};
    end
    check("blank_low_cnt", 32'(lo_cnt), 32'd160);
    check("blank_low_first", 32'(lo_first), 32'd640);
    check("vs_high_row2", 32'(bad), 32'd0);
    check("rgb_bg_a", 32'(rgb100), 32'h202020);
    check("rgb_blank_a", 32'(rgb700), 32'h000000);

    // Half-rate pixel tick: a line takes twice as many clocks, outputs hold on idle edges.
    @(negedge clk);
    start_row = int'(a_row);
    prev_col = a_col; prev_row = a_row; prev_hs = a_hs; prev_blank = a_blank;
    prev_rgb = {a_r, a_g, a_b};
    bad = 0; p = 0; found = 1'b0;
    for (int i = 1; i <= 4000 && !found; i++) begin
      en_i = (i % 2 == 0);
      @(negedge clk);
      if (!en_i) begin
        if (a_col != prev_col || a_row != prev_row || a_hs != prev_hs ||
            a_blank != prev_blank || {a_r, a_g, a_b} != prev_rgb) bad++;
      end
      prev_col = a_col; prev_row = a_row; prev_hs = a_hs; prev_blank = a_blank;
      prev_rgb = {a_r, a_g, a_b};
      if (int'(a_row) != start_row) begin found = 1'b1; p = i; end
    end
    check("half_rate_line", 32'(p), 32'd1600);
    check("half_rate_hold", 32'(bad), 32'd0);
    en_i = 1'b1;

    // Shrunken raster: reset picture.
    rstn = 1'b0;
    @(negedge clk);
    check("b_rst_row", 32'(b_row), 32'd0);
    check("b_rst_col", 32'(b_col), 32'd0);
    check("b_rst_state", 32'(b_state), 32'(STOP));
    check("b_rst_rgb", 32'({b_r, b_g, b_b}), 32'h202020);
    rstn = 1'b1;
    scan_b(8, first, cnt);
    check("ball_first_x", 32'(first), 32'd28);
    check("ball_width", 32'(cnt), 32'd8);
    check("pix_ball", 32'(line_rgb[28]), 32'hFFFFFF);
    check("pix_left_bg", 32'(line_rgb[27]), 32'h202020);
    check("pix_right_bg", 32'(line_rgb[36]), 32'h202020);
    check("pix_blank", 32'(line_rgb[70]), 32'h000000);
    scan_b(15, first, cnt);
    check("ball_bottom_row", 32'(cnt), 32'd8);
    scan_b(16, first, cnt);
    check("ball_below", 32'(cnt), 32'd0);

    // Frame timing: pulse position, width, period and vsync length.
    wait_fs("fs_first");
    check("fs_row0", 32'(b_row), 32'd0);
    check("fs_col0", 32'(b_col), 32'd0);
    vl = 0; vrow = -1; p = 0; found = 1'b0;
    for (int i = 1; i <= 6000 && !found; i++) begin
      @(negedge clk);
      if (i == 1) check("fs_width", 32'(b_fs), 32'd0);
      if (!b_vs) begin
        vl++;
        if (vrow < 0) vrow = int'(b_row);
      end
      if (b_fs) begin found = 1'b1; p = i; end
    end
    check("fs_period", 32'(p), 32'd2400);
    check("vs_low_clks", 32'(vl), 32'd160);
    check("vs_first_row", 32'(vrow), 32'd26);
    check("stop_state", 32'(b_state), 32'(STOP));
    scan_b(8, first, cnt);
    check("run0_hold_x", 32'(first), 32'd28);

    // Motion: step_x=5 bounces off XMAX=56, step_y=0 keeps the ball on rows 8..15.
    run = 1'b1; step_x = 4'd5; step_y = 4'd0;
    for (int n = 0; n < 8; n++) begin
      wait_fs("fs_move");
      check("move_state", 32'(b_state), 32'(MOVE));
      scan_b(7, first, cnt);
      check("move_row7_empty", 32'(cnt), 32'd0);
      scan_b(8, first, cnt);
      check($sformatf("move_bx_%0d", n), 32'(first), 32'(exp_bx[n]));
      check("move_width", 32'(cnt), 32'd8);
    end
    run = 1'b0;
    wait_fs("fs_stop");
    check("stop_again", 32'(b_state), 32'(STOP));
    scan_b(8, first, cnt);
    check("stop_hold_x", 32'(first), 32'd46);

    // Reset in the middle of a frame.
    wait_b(10, 40, "mid_sync");
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_row", 32'(b_row), 32'd0);
    check("mid_rst_col", 32'(b_col), 32'd0);
    check("mid_rst_fs", 32'(b_fs), 32'd0);
    rstn = 1'b1;
    scan_b(8, first, cnt);
    check("mid_rst_x", 32'(first), 32'd28);

    // Reset coinciding with a frame wrap while moving.
    run = 1'b1;
    wait_fs("fs_rearm");
    check("rearm_state", 32'(b_state), 32'(MOVE));
    scan_b(8, first, cnt);
    check("rearm_x", 32'(first), 32'd33);
    wait_b(29, 79, "wrap_sync");
    rstn = 1'b0;
    @(negedge clk);
    check("wrap_rst_row", 32'(b_row), 32'd0);
    check("wrap_rst_col", 32'(b_col), 32'd0);
    check("wrap_rst_fs", 32'(b_fs), 32'd0);
    check("wrap_rst_state", 32'(b_state), 32'(STOP));
    rstn = 1'b1; run = 1'b0;
    scan_b(8, first, cnt);
    check("wrap_rst_x", 32'(first), 32'd28);
    check("wrap_rst_w", 32'(cnt), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
